kernel_cc_start_token_dispatch: RTL and testbench

- Consumer end of a dataflow start-token FIFO (shift-register FIFO, first-word-fall-through read side).
- Pops start tokens from the FIFO and issues them to one downstream dataflow task (for example write_back) using the ap_start/ap_ready/ap_done/ap_continue handshake.
- Tracks how many task invocations are in flight and throttles issue at a configurable limit.
- Exposes issue/done counters and an idle flag for kernel-level control and debug.

---
 rtl/kernel_cc_start_token_dispatch.sv | 143 ++++++++++++++
 tb/tb_kernel_cc_start_token_dispatch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_cc_start_token_dispatch.sv
// Start-token dispatcher: pops start tokens from a first-word-fall-through
// FIFO and issues them to one downstream dataflow task over the
// ap_start/ap_ready/ap_done/ap_continue handshake. It limits the number of
// in-flight invocations and keeps issue/done counters plus idle and
// underflow status for kernel-level control and debug.
module kernel_cc_start_token_dispatch #(
  parameter int DATA_WIDTH   = 1,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_read,
  output logic                  fifo_read_ce,
  output logic                  task_start,
  output logic [DATA_WIDTH-1:0] task_token,
  input  logic                  task_ready,
  input  logic                  task_done,
  output logic                  task_continue,
  output logic [CNT_W-1:0]      inflight,
  output logic [31:0]           issued_cnt,
  output logic [31:0]           done_cnt,
  output logic                  idle,
  output logic                  err_underflow
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  // The limit is carried one bit wider so (inflight + 1) never wraps.
  localparam logic [CNT_W:0] MAX_L = (CNT_W + 1)'(MAX_INFLIGHT);

  state_t                state;
  logic [DATA_WIDTH-1:0] token_q;

  logic           can_pop;
  logic           hs;
  logic [CNT_W:0] inflight_ext;
  logic [CNT_W:0] inflight_inc;
  logic           room_idle;
  logic           room_chain;
  logic           done_ok;
  logic           underflow;

  assign can_pop      = enable & fifo_empty_n;
  assign hs           = task_start & task_ready;
  assign inflight_ext = {1'b0, inflight};
  assign inflight_inc = inflight_ext + {{CNT_W{1'b0}}, 1'b1};

  // The throttle only looks at the registered count; a done pulse in the
  // same cycle frees its slot one cycle later.
  assign room_idle  = (inflight_ext < MAX_L);
  // In the handshake cycle this start is about to count, so one more must fit.
  assign room_chain = (inflight_inc < MAX_L);

  // A done is legitimate if something is in flight or is being started now.
  assign done_ok   = task_done & (hs | (inflight != '0));
  assign underflow = task_done & ~hs & (inflight == '0);

  assign task_token = token_q;

  // Pop decision: start a new issue from idle, or chain the next token in
  // the cycle the current one is accepted. Forced low while reset is held.
  always_comb begin
    fifo_read = 1'b0;
    if (reset) begin
      case (state)
        S_IDLE:  fifo_read = can_pop & room_idle;
        S_ISSUE: fifo_read = hs & can_pop & room_chain;
        default: fifo_read = 1'b0;
      endcase
    end
  end

  assign idle = (state == S_IDLE) && (inflight == '0) && !fifo_read;

  // Issue FSM: holds task_start and the captured token until accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      token_q       <= '0;
      task_start    <= 1'b0;
      fifo_read_ce  <= 1'b0;
      task_continue <= 1'b0;
    end else begin
      fifo_read_ce  <= 1'b1;
      task_continue <= 1'b1;
      if (fifo_read) begin
        token_q <= fifo_dout;
      end
      case (state)
        S_IDLE: begin
          if (fifo_read) begin
            state      <= S_ISSUE;
            task_start <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Without a chained pop the accepted start ends the issue burst.
          if (hs && !fifo_read) begin
            state      <= S_IDLE;
            task_start <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          task_start <= 1'b0;
        end
      endcase
    end
  end

  // In-flight bookkeeping, wrapping event counters and sticky underflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight      <= '0;
      issued_cnt    <= '0;
      done_cnt      <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (hs) begin
        issued_cnt <= issued_cnt + 32'd1;
      end
      if (done_ok) begin
        done_cnt <= done_cnt + 32'd1;
      end
      if (hs && !done_ok) begin
        inflight <= inflight + CNT_W'(1);
      end else if (!hs && done_ok) begin
        inflight <= inflight - CNT_W'(1);
      end
      if (underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kernel_cc_start_token_dispatch.sv
// Bench for the start-token dispatcher. Instance 0 uses an in-flight limit
// of 4, instance 1 a limit of 2. A queue-based FIFO model feeds each
// instance; every token loaded is also pushed to a per-instance scoreboard
// and popped/compared when the instance's start handshake completes.
module tb_kernel_cc_start_token_dispatch;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          enable_s       [2];
  logic          fifo_empty_n_s [2];
  logic [DW-1:0] fifo_dout_s    [2];
  logic          fifo_read_s    [2];
  logic          fifo_read_ce_s [2];
  logic          task_start_s   [2];
  logic [DW-1:0] task_token_s   [2];
  logic          task_ready_s   [2];
  logic          task_done_s    [2];
  logic          task_continue_s[2];
  logic [2:0]    inflight_s     [2];
  logic [31:0]   issued_s       [2];
  logic [31:0]   done_s         [2];
  logic          idle_s         [2];
  logic          err_s          [2];

  kernel_cc_start_token_dispatch #(
    .DATA_WIDTH(DW), .MAX_INFLIGHT(4), .CNT_W(3)
  ) dut_a (
    .clk(clk), .reset(rst_n), .enable(enable_s[0]),
    .fifo_empty_n(fifo_empty_n_s[0]), .fifo_dout(fifo_dout_s[0]),
    .fifo_read(fifo_read_s[0]), .fifo_read_ce(fifo_read_ce_s[0]),
    .task_start(task_start_s[0]), .task_token(task_token_s[0]),
    .task_ready(task_ready_s[0]), .task_done(task_done_s[0]),
    .task_continue(task_continue_s[0]), .inflight(inflight_s[0]),
    .issued_cnt(issued_s[0]), .done_cnt(done_s[0]),
    .idle(idle_s[0]), .err_underflow(err_s[0])
  );

  kernel_cc_start_token_dispatch #(
    .DATA_WIDTH(DW), .MAX_INFLIGHT(2), .CNT_W(3)
  ) dut_b (
    .clk(clk), .reset(rst_n), .enable(enable_s[1]),
    .fifo_empty_n(fifo_empty_n_s[1]), .fifo_dout(fifo_dout_s[1]),
    .fifo_read(fifo_read_s[1]), .fifo_read_ce(fifo_read_ce_s[1]),
    .task_start(task_start_s[1]), .task_token(task_token_s[1]),
    .task_ready(task_ready_s[1]), .task_done(task_done_s[1]),
    .task_continue(task_continue_s[1]), .inflight(inflight_s[1]),
    .issued_cnt(issued_s[1]), .done_cnt(done_s[1]),
    .idle(idle_s[1]), .err_underflow(err_s[1])
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] fq0[$];
  logic [DW-1:0] fq1[$];
  logic [DW-1:0] sb0[$];
  logic [DW-1:0] sb1[$];

  logic rd_last [2];
  logic st_last [2];
  int   rd_cnt  [2];
  int   st_cnt  [2];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty_n_s[0] = (fq0.size() != 0);
    fifo_dout_s[0]    = (fq0.size() != 0) ? fq0[0] : '0;
    fifo_empty_n_s[1] = (fq1.size() != 0);
    fifo_dout_s[1]    = (fq1.size() != 0) ? fq1[0] : '0;
  endtask

  task automatic push_token(input int d, input logic [DW-1:0] v);
    if (d == 0) begin
      fq0.push_back(v);
      sb0.push_back(v);
    end else begin
      fq1.push_back(v);
      sb1.push_back(v);
    end
    refresh();
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      rd_cnt[d] = 0;
      st_cnt[d] = 0;
    end
  endtask

  // One clock cycle: sample before the edge, then pop the FIFO model.
  task automatic tick();
    logic [DW-1:0] exp_tok;
    logic [DW-1:0] dummy;
    int            sb_size;
    #1;
    for (int d = 0; d < 2; d++) begin
      rd_last[d] = fifo_read_s[d];
      st_last[d] = task_start_s[d];
      if (rd_last[d]) begin
        rd_cnt[d]++;
        check_value("pop_nonempty", 32'(fifo_empty_n_s[d]), 32'd1);
      end
      if (st_last[d]) st_cnt[d]++;
      if (task_start_s[d] && task_ready_s[d]) begin
        sb_size = (d == 0) ? sb0.size() : sb1.size();
        check_value("sb_pending", 32'(sb_size != 0), 32'd1);
        if (sb_size != 0) begin
          if (d == 0) exp_tok = sb0.pop_front();
          else        exp_tok = sb1.pop_front();
          check_value("token", 32'(task_token_s[d]), 32'(exp_tok));
          $display("issue dut=%0d token=0x%0h exp=0x%0h t=%0t", d, task_token_s[d], exp_tok, $time);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rd_last[0] && fq0.size() != 0) dummy = fq0.pop_front();
    if (rd_last[1] && fq1.size() != 0) dummy = fq1.pop_front();
    refresh();
    #1;
  endtask

  initial begin
    logic [3:0] rd_pat;
    logic [3:0] st_pat;
    logic [4:0] rd_pat5;
    logic [4:0] st_pat5;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      enable_s[d]     = 1'b1;
      task_ready_s[d] = 1'b0;
      task_done_s[d]  = 1'b0;
      rd_last[d]      = 1'b0;
      st_last[d]      = 1'b0;
    end
    clear_counts();
    refresh();

    // Reset held with a token waiting on instance 0
    push_token(0, 8'h01);
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check_value("rst_fifo_read", 32'(fifo_read_s[d]), 32'd0);
      check_value("rst_task_start", 32'(task_start_s[d]), 32'd0);
      check_value("rst_idle", 32'(idle_s[d]), 32'd1);
      check_value("rst_inflight", 32'(inflight_s[d]), 32'd0);
      check_value("rst_issued", issued_s[d], 32'd0);
      check_value("rst_done", done_s[d], 32'd0);
      check_value("rst_read_ce", 32'(fifo_read_ce_s[d]), 32'd0);
      check_value("rst_continue", 32'(task_continue_s[d]), 32'd0);
      check_value("rst_err", 32'(err_s[d]), 32'd0);
    end

    // Release: the pop is requested immediately and lands on the first edge
    rst_n = 1'b1;
    #1;
    check_value("first_pop", 32'(fifo_read_s[0]), 32'd1);
    clear_counts();
    tick();
    check_value("single_start", 32'(task_start_s[0]), 32'd1);
    check_value("single_token", 32'(task_token_s[0]), 32'h01);
    check_value("read_ce_up", 32'(fifo_read_ce_s[0]), 32'd1);
    check_value("continue_up", 32'(task_continue_s[0]), 32'd1);
    tick();
    tick();
    task_ready_s[0] = 1'b1;
    tick();
    task_ready_s[0] = 1'b0;
    check_value("single_reads", 32'(rd_cnt[0]), 32'd1);
    check_value("single_start_cycles", 32'(st_cnt[0]), 32'd3);
    check_value("single_issued", issued_s[0], 32'd1);
    check_value("single_inflight", 32'(inflight_s[0]), 32'd1);
    check_value("single_start_low", 32'(task_start_s[0]), 32'd0);
    check_value("single_busy", 32'(idle_s[0]), 32'd0);
    task_done_s[0] = 1'b1;
    tick();
    task_done_s[0] = 1'b0;
    check_value("single_done_inflight", 32'(inflight_s[0]), 32'd0);
    check_value("single_done_cnt", done_s[0], 32'd1);
    check_value("single_idle", 32'(idle_s[0]), 32'd1);

    // Back-to-back: three tokens, ready tied high, limit 4
    clear_counts();
    task_ready_s[0] = 1'b1;
    push_token(0, 8'hA1);
    push_token(0, 8'hA2);
    push_token(0, 8'hA3);
    rd_pat = 4'b0111;
    st_pat = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_value("b2b_read", 32'(rd_last[0]), 32'(rd_pat[i]));
      check_value("b2b_start", 32'(st_last[0]), 32'(st_pat[i]));
    end
    check_value("b2b_reads", 32'(rd_cnt[0]), 32'd3);
    check_value("b2b_starts", 32'(st_cnt[0]), 32'd3);
    check_value("b2b_issued", issued_s[0], 32'd4);
    check_value("b2b_inflight", 32'(inflight_s[0]), 32'd3);
    check_value("b2b_start_low", 32'(task_start_s[0]), 32'd0);
    task_done_s[0] = 1'b1;
    repeat (3) tick();
    task_done_s[0] = 1'b0;
    task_ready_s[0] = 1'b0;
    check_value("b2b_drain_inflight", 32'(inflight_s[0]), 32'd0);
    check_value("b2b_drain_done", done_s[0], 32'd4);
    check_value("b2b_idle", 32'(idle_s[0]), 32'd1);

    // Throttle on instance 1 (limit 2): four tokens, no done
    clear_counts();
    task_ready_s[1] = 1'b1;
    push_token(1, 8'hB1);
    push_token(1, 8'hB2);
    push_token(1, 8'hB3);
    push_token(1, 8'hB4);
    rd_pat5 = 5'b00011;
    st_pat5 = 5'b00110;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("thr_read", 32'(rd_last[1]), 32'(rd_pat5[i]));
      check_value("thr_start", 32'(st_last[1]), 32'(st_pat5[i]));
    end
    check_value("thr_reads", 32'(rd_cnt[1]), 32'd2);
    check_value("thr_inflight", 32'(inflight_s[1]), 32'd2);
    check_value("thr_issued", issued_s[1], 32'd2);
    check_value("thr_read_held", 32'(fifo_read_s[1]), 32'd0);
    task_done_s[1] = 1'b1;
    tick();
    task_done_s[1] = 1'b0;
    check_value("thr_no_pop_on_done", 32'(rd_last[1]), 32'd0);
    check_value("thr_inflight_1", 32'(inflight_s[1]), 32'd1);
    check_value("thr_done_cnt", done_s[1], 32'd1);
    check_value("thr_read_next", 32'(fifo_read_s[1]), 32'd1);
    tick();
    check_value("thr_pop_after_drop", 32'(rd_last[1]), 32'd1);
    check_value("thr_restart", 32'(task_start_s[1]), 32'd1);

    // Handshake and done in the same cycle at inflight=1
    task_done_s[1] = 1'b1;
    tick();
    task_done_s[1] = 1'b0;
    check_value("sim_inflight", 32'(inflight_s[1]), 32'd1);
    check_value("sim_issued", issued_s[1], 32'd3);
    check_value("sim_done", done_s[1], 32'd2);
    tick();
    tick();
    task_ready_s[1] = 1'b0;
    check_value("sim_last_inflight", 32'(inflight_s[1]), 32'd2);
    check_value("sim_last_issued", issued_s[1], 32'd4);
    task_done_s[1] = 1'b1;
    repeat (2) tick();
    task_done_s[1] = 1'b0;
    check_value("pre_uf_inflight", 32'(inflight_s[1]), 32'd0);
    check_value("pre_uf_done", done_s[1], 32'd4);
    check_value("pre_uf_err", 32'(err_s[1]), 32'd0);

    // Done pulse with nothing in flight
    task_done_s[1] = 1'b1;
    tick();
    task_done_s[1] = 1'b0;
    check_value("uf_err", 32'(err_s[1]), 32'd1);
    check_value("uf_done", done_s[1], 32'd4);
    check_value("uf_inflight", 32'(inflight_s[1]), 32'd0);
    tick();
    check_value("uf_sticky", 32'(err_s[1]), 32'd1);
    check_value("uf_other_err", 32'(err_s[0]), 32'd0);

    // enable drops while a popped token waits for ready
    clear_counts();
    push_token(0, 8'hC1);
    push_token(0, 8'hC2);
    push_token(0, 8'hC3);
    tick();
    enable_s[0] = 1'b0;
    tick();
    check_value("en_start_held", 32'(st_last[0]), 32'd1);
    check_value("en_no_pop", 32'(rd_last[0]), 32'd0);
    task_ready_s[0] = 1'b1;
    tick();
    task_ready_s[0] = 1'b0;
    check_value("en_issued", issued_s[0], 32'd5);
    check_value("en_inflight", 32'(inflight_s[0]), 32'd1);
    check_value("en_start_low", 32'(task_start_s[0]), 32'd0);
    repeat (2) tick();
    check_value("en_reads", 32'(rd_cnt[0]), 32'd1);
    task_done_s[0] = 1'b1;
    tick();
    task_done_s[0] = 1'b0;
    check_value("en_inflight_0", 32'(inflight_s[0]), 32'd0);
    check_value("en_done", done_s[0], 32'd5);
    check_value("en_idle", 32'(idle_s[0]), 32'd1);
    check_value("en_fifo_left", 32'(fq0.size()), 32'd2);
    check_value("en_sb_left", 32'(sb0.size()), 32'd2);
    fq0.delete();
    sb0.delete();
    refresh();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
